// File: rtl/comparator_2bit.sv
// Registered unsigned magnitude/equality comparator.
// z/gt/lt are one-hot after the first capture edge and all zero while in reset.
module comparator_2bit #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             z,
    output logic             gt,
    output logic             lt
);

    logic eq_next;
    logic gt_next;
    logic lt_next;

    always_comb begin
        eq_next = 1'b0;
        gt_next = 1'b0;
        lt_next = 1'b0;
        if (x == y) begin
            eq_next = 1'b1;
        end else if (x > y) begin
            gt_next = 1'b1;
        end else begin
            lt_next = 1'b1;
        end
    end

    // The three output flops are the only state; reset clears them asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z  <= 1'b0;
            gt <= 1'b0;
            lt <= 1'b0;
        end else begin
            z  <= eq_next;
            gt <= gt_next;
            lt <= lt_next;
        end
    end

endmodule

// File: tb/tb_comparator_2bit.sv
// Scoreboard bench for comparator_2bit: expected {z,gt,lt} is queued when operands
// are driven and compared one edge later by an independent monitor.
module tb_comparator_2bit;

    logic       clk;
    logic       rst;
    logic [1:0] x;
    logic [1:0] y;
    logic       z;
    logic       gt;
    logic       lt;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [2:0] expQueue[$];

    comparator_2bit #(.WIDTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .x  (x),
        .y  (y),
        .z  (z),
        .gt (gt),
        .lt (lt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2:0] expectFlags(input logic [1:0] a, input logic [1:0] b);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        if (ia == ib)     return 3'b100;
        else if (ia > ib) return 3'b010;
        else              return 3'b001;
    endfunction

    task automatic checkOutput(input string tag, input logic [2:0] actual, input logic [2:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got {z,gt,lt}=%b expected %b at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive operands away from the capture edge and queue the result due one edge later.
    task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b);
        @(negedge clk);
        x = a;
        y = b;
        expQueue.push_back(expectFlags(a, b));
    endtask

    // Monitor: after every capture edge out of reset, retire one queued expectation.
    initial begin
        logic [2:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && expQueue.size() > 0) begin
                exp = expQueue.pop_front();
                checkOutput("flags", {z, gt, lt}, exp);
                checkOutput("onehot", {2'b00, ($countones({z, gt, lt}) == 1)}, 3'b001);
            end
        end
    end

    initial begin
        rst = 1'b1;
        x   = 2'd2;
        y   = 2'd2;
        #1;
        checkOutput("reset_async", {z, gt, lt}, 3'b000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_release_idle", {z, gt, lt}, 3'b000);
        expQueue.push_back(expectFlags(2'd2, 2'd2));

        for (int i = 0; i < 16; i++) begin
            applyStimulus(2'(i >> 2), 2'(i & 3));
        end

        applyStimulus(2'd1, 2'd1);
        applyStimulus(2'd1, 2'd2);

        applyStimulus(2'd3, 2'd0);
        applyStimulus(2'd0, 2'd3);
        applyStimulus(2'd3, 2'd3);

        // Operand change between edges must not reach the outputs early.
        applyStimulus(2'd1, 2'd3);
        @(posedge clk);
        #2;
        x = 2'd3;
        #1;
        checkOutput("hold_between_edges", {z, gt, lt}, 3'b001);
        expQueue.push_back(expectFlags(2'd3, 2'd3));

        // Short reset pulse while z is high.
        @(posedge clk);
        #2;
        checkOutput("z_before_pulse", {z, gt, lt}, 3'b100);
        rst = 1'b1;
        #1;
        checkOutput("reset_pulse_async", {z, gt, lt}, 3'b000);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("reset_pulse_hold", {z, gt, lt}, 3'b000);
        expQueue.push_back(expectFlags(2'd3, 2'd3));

        for (int c = 0; c < 4 && expQueue.size() > 0; c++) begin
            @(posedge clk);
            #2;
        end
        checkOutput("queue_drained", {2'b00, (expQueue.size() == 0)}, 3'b001);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
